esdi_read_task_scheduler: RTL and testbench

- Sequences multi-sector reads for the ESDI sector-timing read-gate block.
- Accepts one request (start sector, sector count) and emits per-sector task entries on a valid/ready stream into the timing block's task FIFO.
- Limits tasks in flight with a credit window, counts completions, detects stalled reads by counting index revolutions, and returns one status word per request.

---
 rtl/esdi_read_task_scheduler_if.sv | 31 +++
 rtl/esdi_read_task_scheduler.sv | 171 +++++++++++++++++
 tb/tb_esdi_read_task_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/esdi_read_task_scheduler_if.sv
// Request, task and status channels of the ESDI read task scheduler.
// The master modport is the scheduler; the slave modport is the host / timing-block side.
interface esdi_read_task_scheduler_if #(
    parameter int SECTOR_W = 16
);
    logic                req_valid;
    logic                req_ready;
    logic [SECTOR_W-1:0] req_start;
    logic [SECTOR_W-1:0] req_count;
    logic                task_valid;
    logic                task_ready;
    logic [SECTOR_W-1:0] task_sector;
    logic                task_done;
    logic                task_flush;
    logic                status_valid;
    logic                status_ready;
    logic [1:0]          status_code;
    logic [SECTOR_W-1:0] status_completed;

    modport master (
        input  req_valid, req_start, req_count, task_ready, task_done, status_ready,
        output req_ready, task_valid, task_sector, task_flush,
               status_valid, status_code, status_completed
    );

    modport slave (
        output req_valid, req_start, req_count, task_ready, task_done, status_ready,
        input  req_ready, task_valid, task_sector, task_flush,
               status_valid, status_code, status_completed
    );
endinterface

// File: rtl/esdi_read_task_scheduler.sv
// ESDI read task scheduler: turns one (start, count) request into per-sector
// tasks for the read-gate timing block, bounded by a credit window, with
// revolution-based stall detection and one status word per request.
// Optional build macro ESDI_SCHED_INTERLEAVE_EN adds a 4-bit interleave input
// that sets the sector step (0 behaves as 1).
module esdi_read_task_scheduler #(
    parameter int SECTOR_W        = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int REV_LIMIT       = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [SECTOR_W-1:0]         sectors_per_track,
`ifdef ESDI_SCHED_INTERLEAVE_EN
    input  logic [3:0]                  interleave,
`endif
    input  logic                        index_pulse,
    esdi_read_task_scheduler_if.master  bus,
    output logic                        busy,
    output logic [7:0]                  outstanding
);
    typedef enum logic [1:0] {IDLE, ISSUE, STATUS} state_t;

    localparam logic [SECTOR_W-1:0] MAX_OUT_C   = SECTOR_W'(MAX_OUTSTANDING);
    localparam logic [SECTOR_W-1:0] REV_LIMIT_C = SECTOR_W'(REV_LIMIT);

    state_t              state_q, state_d;
    logic [1:0]          code_q, code_d;
    logic                flush_q, flush_d;
    logic [SECTOR_W-1:0] count_q, issued_q, completed_q, rev_q, sector_q, outstanding_q;
    logic [SECTOR_W-1:0] step_in, step_cur;
    logic [SECTOR_W:0]   sector_sum, spt_ext;
    logic [SECTOR_W-1:0] sector_adv;
    logic                accept, task_fire, done_eff, timeout_hit, all_done, bad_req;

`ifdef ESDI_SCHED_INTERLEAVE_EN
    logic [SECTOR_W-1:0] step_q;
    assign step_in  = (interleave == 4'd0) ? SECTOR_W'(1) : SECTOR_W'(interleave);
    assign step_cur = step_q;
    assign bad_req  = (bus.req_start >= sectors_per_track) || (sectors_per_track == '0) ||
                      (step_in >= sectors_per_track);
`else
    assign step_in  = SECTOR_W'(1);
    assign step_cur = step_in;
    assign bad_req  = (bus.req_start >= sectors_per_track) || (sectors_per_track == '0);
`endif

    assign accept      = bus.req_valid && bus.req_ready;
    assign task_fire   = bus.task_valid && bus.task_ready;
    assign done_eff    = bus.task_done && (state_q == ISSUE) && (outstanding_q != '0);
    assign timeout_hit = (state_q == ISSUE) && index_pulse && !done_eff &&
                         ((rev_q + SECTOR_W'(1)) >= REV_LIMIT_C);
    assign all_done    = done_eff && ((completed_q + SECTOR_W'(1)) == count_q);

    // single-subtract modulo keeps the next sector inside the track
    assign spt_ext    = {1'b0, sectors_per_track};
    assign sector_sum = {1'b0, sector_q} + {1'b0, step_cur};
    assign sector_adv = (sector_sum >= spt_ext) ? SECTOR_W'(sector_sum - spt_ext)
                                                : sector_sum[SECTOR_W-1:0];

    assign bus.req_ready        = (state_q == IDLE) && enable;
    assign bus.task_valid       = (state_q == ISSUE) && (issued_q < count_q) &&
                                  (outstanding_q < MAX_OUT_C) && !timeout_hit;
    assign bus.task_sector      = sector_q;
    assign bus.task_flush       = flush_q;
    assign bus.status_valid     = (state_q == STATUS);
    assign bus.status_code      = code_q;
    assign bus.status_completed = completed_q;
    assign busy                 = (state_q != IDLE);
    assign outstanding          = 8'(outstanding_q);

    // state, status code and flush pulse register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            code_q  <= 2'd0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            flush_q <= flush_d;
        end
    end

    // next-state decode; abort beats completion, completion beats timeout
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        flush_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.req_count == '0) begin
                        state_d = STATUS;
                        code_d  = 2'd0;
                    end else if (bad_req) begin
                        state_d = STATUS;
                        code_d  = 2'd1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!enable) begin
                    state_d = STATUS;
                    code_d  = 2'd3;
                    flush_d = 1'b1;
                end else if (all_done) begin
                    state_d = STATUS;
                    code_d  = 2'd0;
                end else if (timeout_hit) begin
                    state_d = STATUS;
                    code_d  = 2'd2;
                    flush_d = 1'b1;
                end
            end
            STATUS: begin
                if (bus.status_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // request latching, sector advance and issue/completion/revolution counters
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q       <= '0;
            issued_q      <= '0;
            completed_q   <= '0;
            rev_q         <= '0;
            sector_q      <= '0;
            outstanding_q <= '0;
`ifdef ESDI_SCHED_INTERLEAVE_EN
            step_q        <= '0;
`endif
        end else if (state_q == IDLE) begin
            if (accept) begin
                count_q     <= bus.req_count;
                sector_q    <= bus.req_start;
                issued_q    <= '0;
                completed_q <= '0;
                rev_q       <= '0;
`ifdef ESDI_SCHED_INTERLEAVE_EN
                step_q      <= step_in;
`endif
            end
        end else if (state_q == ISSUE) begin
            if (task_fire) begin
                issued_q <= issued_q + SECTOR_W'(1);
                sector_q <= sector_adv;
            end
            if (done_eff) begin
                completed_q <= completed_q + SECTOR_W'(1);
                rev_q       <= '0;
            end else if (index_pulse) begin
                rev_q <= rev_q + SECTOR_W'(1);
            end
            if (flush_d) begin
                outstanding_q <= '0;
            end else if (task_fire && !done_eff) begin
                outstanding_q <= outstanding_q + SECTOR_W'(1);
            end else if (!task_fire && done_eff) begin
                outstanding_q <= outstanding_q - SECTOR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_esdi_read_task_scheduler.sv
// Scoreboard bench for esdi_read_task_scheduler: expected tasks and status
// words are queued when requests are issued; monitors pop and compare.
module tb_esdi_read_task_scheduler;
    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] spt;
    logic        index_pulse;
    logic        busy;
    logic [7:0]  outstanding;
    logic        manual_done;
    logic        auto_done;
`ifdef ESDI_SCHED_INTERLEAVE_EN
    logic [3:0]  interleave;
`endif

    typedef struct {
        logic [1:0]  code;
        logic [15:0] completed;
    } status_exp_t;

    logic [15:0] task_q[$];
    status_exp_t status_q[$];
    int          due_q[$];
    int          total = 0;
    int          bad = 0;
    int          task_seen = 0;
    int          flush_cycles = 0;
    int          cyc_cnt = 0;

    esdi_read_task_scheduler_if #(.SECTOR_W(16)) bus ();

    esdi_read_task_scheduler #(
        .SECTOR_W(16),
        .MAX_OUTSTANDING(4),
        .REV_LIMIT(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .sectors_per_track(spt),
`ifdef ESDI_SCHED_INTERLEAVE_EN
        .interleave(interleave),
`endif
        .index_pulse(index_pulse),
        .bus(bus),
        .busy(busy),
        .outstanding(outstanding)
    );

    // free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // hard stop in case something never terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        manual_done = 1'b1;
        tick(1);
        manual_done = 1'b0;
    endtask

    task automatic pulse_index();
        index_pulse = 1'b1;
        tick(1);
        index_pulse = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [15:0] start, input logic [15:0] count);
        int waited = 0;
        bus.req_start = start;
        bus.req_count = count;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && waited < 50) begin
            tick(1);
            waited++;
        end
        check_output("req_accept", {31'd0, bus.req_ready}, 32'd1);
        tick(1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        check_output("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic push_status(input logic [1:0] code, input logic [15:0] completed);
        status_exp_t e;
        e.code = code;
        e.completed = completed;
        status_q.push_back(e);
    endtask

    // task_done driver: automatic completions 10 cycles after issue, plus manual pulses
    initial begin
        bus.task_done = 1'b0;
        forever begin
            logic hit;
            @(negedge clk);
            if (auto_done && bus.task_valid && bus.task_ready) due_q.push_back(cyc_cnt + 10);
            @(posedge clk);
            #2;
            cyc_cnt++;
            hit = 1'b0;
            if (due_q.size() > 0 && due_q[0] <= cyc_cnt) begin
                void'(due_q.pop_front());
                hit = 1'b1;
            end
            bus.task_done = hit || manual_done;
        end
    end

    // task stream monitor
    always @(negedge clk) begin
        if (!reset && bus.task_valid && bus.task_ready) begin
            task_seen++;
            if (task_q.size() == 0) check_output("task_unexpected", {16'd0, bus.task_sector}, 32'hFFFF);
            else check_output("task_sector", {16'd0, bus.task_sector}, {16'd0, task_q.pop_front()});
        end
    end

    // status stream monitor
    always @(negedge clk) begin
        if (!reset && bus.status_valid && bus.status_ready) begin
            if (status_q.size() == 0) begin
                check_output("status_unexpected", {30'd0, bus.status_code}, 32'hFFFF);
            end else begin
                status_exp_t e;
                e = status_q.pop_front();
                check_output("status_code", {30'd0, bus.status_code}, {30'd0, e.code});
                check_output("status_completed", {16'd0, bus.status_completed}, {16'd0, e.completed});
            end
        end
    end

    // flush pulse counter
    always @(negedge clk) begin
        if (bus.task_flush) flush_cycles++;
    end

    initial begin
        int seen0;
        int fl0;
        reset = 1'b1;
        enable = 1'b1;
        spt = 16'd34;
        index_pulse = 1'b0;
        manual_done = 1'b0;
        auto_done = 1'b0;
`ifdef ESDI_SCHED_INTERLEAVE_EN
        interleave = 4'd0;
`endif
        bus.req_valid = 1'b0;
        bus.req_start = '0;
        bus.req_count = '0;
        bus.task_ready = 1'b1;
        bus.status_ready = 1'b1;
        tick(3);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_task_valid", {31'd0, bus.task_valid}, 32'd0);
        check_output("rst_status_valid", {31'd0, bus.status_valid}, 32'd0);
        check_output("rst_flush", {31'd0, bus.task_flush}, 32'd0);
        check_output("rst_outstanding", {24'd0, outstanding}, 32'd0);
        check_output("rst_code", {30'd0, bus.status_code}, 32'd0);
        check_output("rst_completed", {16'd0, bus.status_completed}, 32'd0);
        reset = 1'b0;
        tick(1);
        check_output("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

        $display("[TB] wrap-around read");
        spt = 16'd34;
        auto_done = 1'b1;
        task_q.push_back(16'd32); task_q.push_back(16'd33); task_q.push_back(16'd0);
        task_q.push_back(16'd1);  task_q.push_back(16'd2);
        push_status(2'd0, 16'd5);
        apply_stimulus(16'd32, 16'd5);
        wait_idle(200);
        auto_done = 1'b0;

        $display("[TB] credit window");
        spt = 16'd100;
        for (int i = 0; i < 8; i++) task_q.push_back(16'(10 + i));
        push_status(2'd0, 16'd8);
        seen0 = task_seen;
        apply_stimulus(16'd10, 16'd8);
        tick(8);
        check_output("window_outstanding", {24'd0, outstanding}, 32'd4);
        check_output("window_task_valid", {31'd0, bus.task_valid}, 32'd0);
        check_output("window_issued", task_seen - seen0, 32'd4);
        pulse_done();
        check_output("credit_task_valid", {31'd0, bus.task_valid}, 32'd1);
        check_output("credit_outstanding", {24'd0, outstanding}, 32'd3);
        tick(1);
        check_output("credit_refill", {24'd0, outstanding}, 32'd4);
        check_output("credit_issued", task_seen - seen0, 32'd5);
        for (int i = 0; i < 7; i++) begin
            pulse_done();
            tick(2);
        end
        wait_idle(50);

        $display("[TB] revolution timeout");
        spt = 16'd50;
        fl0 = flush_cycles;
        task_q.push_back(16'd5); task_q.push_back(16'd6); task_q.push_back(16'd7);
        push_status(2'd2, 16'd1);
        apply_stimulus(16'd5, 16'd3);
        tick(5);
        pulse_done();
        tick(2);
        pulse_index();
        tick(2);
        pulse_index();
        tick(2);
        check_output("pre_timeout_busy", {31'd0, busy}, 32'd1);
        pulse_index();
        check_output("timeout_flush", {31'd0, bus.task_flush}, 32'd1);
        check_output("timeout_outstanding", {24'd0, outstanding}, 32'd0);
        wait_idle(20);
        check_output("timeout_flush_cycles", flush_cycles - fl0, 32'd1);

        $display("[TB] abort with held status");
        fl0 = flush_cycles;
        bus.status_ready = 1'b0;
        bus.task_ready = 1'b0;
        task_q.push_back(16'd0); task_q.push_back(16'd1);
        push_status(2'd3, 16'd0);
        apply_stimulus(16'd0, 16'd6);
        bus.task_ready = 1'b1;
        tick(2);
        bus.task_ready = 1'b0;
        enable = 1'b0;
        tick(1);
        check_output("abort_flush", {31'd0, bus.task_flush}, 32'd1);
        check_output("abort_outstanding", {24'd0, outstanding}, 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check_output("hold_status_valid", {31'd0, bus.status_valid}, 32'd1);
            check_output("hold_code", {30'd0, bus.status_code}, 32'd3);
            check_output("hold_completed", {16'd0, bus.status_completed}, 32'd0);
            check_output("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.status_ready = 1'b1;
        tick(1);
        check_output("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check_output("abort_flush_cycles", flush_cycles - fl0, 32'd1);
        bus.task_ready = 1'b1;

        $display("[TB] bad request and empty request");
        spt = 16'd34;
        seen0 = task_seen;
        push_status(2'd1, 16'd0);
        apply_stimulus(16'd40, 16'd3);
        wait_idle(20);
        push_status(2'd0, 16'd0);
        apply_stimulus(16'd3, 16'd0);
        wait_idle(20);
        check_output("no_tasks_issued", task_seen - seen0, 32'd0);

        $display("[TB] simultaneous issue and done, then reset");
        spt = 16'd100;
        bus.task_ready = 1'b0;
        task_q.push_back(16'd20); task_q.push_back(16'd21); task_q.push_back(16'd22);
        apply_stimulus(16'd20, 16'd4);
        bus.task_ready = 1'b1;
        tick(2);
        check_output("pre_overlap_outstanding", {24'd0, outstanding}, 32'd2);
        manual_done = 1'b1;
        tick(1);
        manual_done = 1'b0;
        bus.task_ready = 1'b0;
        check_output("overlap_outstanding", {24'd0, outstanding}, 32'd2);
        reset = 1'b1;
        tick(1);
        check_output("midrst_busy", {31'd0, busy}, 32'd0);
        check_output("midrst_task_valid", {31'd0, bus.task_valid}, 32'd0);
        check_output("midrst_status_valid", {31'd0, bus.status_valid}, 32'd0);
        check_output("midrst_flush", {31'd0, bus.task_flush}, 32'd0);
        check_output("midrst_outstanding", {24'd0, outstanding}, 32'd0);
        check_output("midrst_completed", {16'd0, bus.status_completed}, 32'd0);
        reset = 1'b0;
        bus.task_ready = 1'b1;
        tick(3);

        check_output("task_queue_left", task_q.size(), 32'd0);
        check_output("status_queue_left", status_q.size(), 32'd0);
        check_output("total_flush_cycles", flush_cycles, 32'd2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
